// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between inst and data masters: data-first priority with a starvation guard,
// combinational request path (addr_ok same cycle), in-order source-ID FIFO routing responses back.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        resp_err
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {LOCK_NONE, LOCK_INST, LOCK_DATA} lock_t;

    lock_t                      lock_q, lock_d;
    logic [CW-1:0]              count;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [MAX_OUTSTANDING-1:0] id_mem;
    logic [SW-1:0]              starve_cnt;

    logic full, empty, starved, grant_inst, grant_data, xfer, pop, head;

    assign full    = (count == CW'(MAX_OUTSTANDING));
    assign empty   = (count == '0);
    assign starved = inst_req && (starve_cnt == SW'(STARVE_LIMIT));

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_size   = 2'd0;
        mem_wstrb  = 4'd0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        lock_d     = lock_q;
        unique case (lock_q)
            LOCK_INST: grant_inst = 1'b1;
            LOCK_DATA: grant_data = 1'b1;
            default: begin
                if (!full) begin
                    if (data_req && !starved) grant_data = 1'b1;
                    else if (inst_req)        grant_inst = 1'b1;
                end
            end
        endcase
        // A held lock keeps the payload stable even while a full FIFO gates mem_req.
        mem_req = ((grant_inst && inst_req) || (grant_data && data_req)) && !full;
        if (grant_inst) begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end else if (grant_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
        if (lock_q == LOCK_NONE) begin
            if (mem_req && !mem_addr_ok) lock_d = grant_data ? LOCK_DATA : LOCK_INST;
        end else if (mem_req && mem_addr_ok) begin
            lock_d = LOCK_NONE;
        end
    end

    assign xfer         = mem_req && mem_addr_ok;
    assign inst_addr_ok = xfer && grant_inst;
    assign data_addr_ok = xfer && grant_data;

    assign pop          = mem_data_ok && !empty;
    assign head         = id_mem[rd_ptr];
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (xfer) id_mem[wr_ptr] <= grant_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q     <= LOCK_NONE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            resp_err   <= 1'b0;
        end else begin
            lock_q <= lock_d;
            if (xfer) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (xfer && !pop)      count <= count + 1'b1;
            else if (!xfer && pop) count <= count - 1'b1;
            if (!inst_req || inst_addr_ok)
                starve_cnt <= '0;
            else if (data_addr_ok && (starve_cnt != SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 1'b1;
            if (mem_data_ok && empty) resp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: per-cycle vector table plus a hand-written starvation sequence.
module tb_sram_like_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    localparam logic [31:0] IWD = 32'h1111_1111;
    localparam logic [31:0] DWD = 32'hDDDD_DDDD;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
    );

    // flags = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, resp_err}
    // src   = master whose payload must appear on mem_* (0: none)
    typedef struct {
        string       name;
        bit          rst, ireq, dreq, aok, dok;
        logic [31:0] rdata, iaddr, daddr;
        logic [5:0]  flags;
        int          src;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input bit rst, input bit ireq, input bit dreq, input bit aok,
                       input bit dok, input logic [31:0] rdata, input logic [31:0] iaddr,
                       input logic [31:0] daddr, input logic [5:0] flags, input int src);
        vec_t v;
        v.name = n; v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok;
        v.rdata = rdata; v.iaddr = iaddr; v.daddr = daddr; v.flags = flags; v.src = src;
        vq.push_back(v);
    endtask

    task automatic drive(input bit rst, input bit ireq, input bit dreq, input bit aok, input bit dok,
                         input logic [31:0] rdata, input logic [31:0] iaddr, input logic [31:0] daddr);
        reset = rst; inst_req = ireq; data_req = dreq; mem_addr_ok = aok; mem_data_ok = dok;
        mem_rdata = rdata; inst_addr = iaddr; data_addr = daddr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        logic [5:0]  got;
        logic [70:0] pay, exp_pay;
        @(negedge clk);
        drive(v.rst, v.ireq, v.dreq, v.aok, v.dok, v.rdata, v.iaddr, v.daddr);
        #1;
        got = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, resp_err};
        checks++;
        if (got !== v.flags) begin
            errors++;
            $display("FAIL %s flags: got %b expected %b", v.name, got, v.flags);
        end
        pay = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
        exp_pay = '0;
        if (v.src == 1)      exp_pay = {1'b0, 2'd2, 4'hF, v.iaddr, IWD};
        else if (v.src == 2) exp_pay = {1'b1, 2'd1, 4'h3, v.daddr, DWD};
        if (v.src != 0 || (!v.ireq && !v.dreq)) begin
            checks++;
            if (pay !== exp_pay) begin
                errors++;
                $display("FAIL %s payload: got %h expected %h", v.name, pay, exp_pay);
            end
        end
        if (v.flags[3]) begin
            checks++;
            if (inst_rdata !== v.rdata) begin
                errors++;
                $display("FAIL %s inst_rdata: got %h expected %h", v.name, inst_rdata, v.rdata);
            end
        end
        if (v.flags[2]) begin
            checks++;
            if (data_rdata !== v.rdata) begin
                errors++;
                $display("FAIL %s data_rdata: got %h expected %h", v.name, data_rdata, v.rdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_ord;
        int    dacc;
        byte   got_c, exp_c;
        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_wdata = IWD;
        data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3; data_wdata = DWD;
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        add("rst_idle",   0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
        // single inst read, response two cycles later
        add("t1_req",     0, 1, 0, 1, 0, 0, 32'h1C000000, 0, 6'b100010, 1);
        add("t1_wait",    0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
        add("t1_resp",    0, 0, 0, 0, 1, 32'h02800C0C, 0, 0, 6'b001000, 0);
        // data lock holds against inst, then inst lock holds against data
        for (int i = 0; i < 3; i++)
            add("t3_lock",  0, 1, 1, 0, 0, 0, 32'h200, 32'h100, 6'b000010, 2);
        add("t3_rel",     0, 1, 1, 1, 0, 0, 32'h200, 32'h100, 6'b010010, 2);
        add("t3_inst",    0, 1, 0, 1, 0, 0, 32'h200, 32'h100, 6'b100010, 1);
        add("t3_r0",      0, 0, 0, 0, 1, 32'hD0, 0, 0, 6'b000100, 0);
        add("t3_r1",      0, 0, 0, 0, 1, 32'hE0, 0, 0, 6'b001000, 0);
        add("t3_ilock",   0, 1, 0, 0, 0, 0, 32'h200, 32'h100, 6'b000010, 1);
        add("t3_ihold",   0, 1, 1, 0, 0, 0, 32'h200, 32'h100, 6'b000010, 1);
        add("t3_irel",    0, 1, 1, 1, 0, 0, 32'h200, 32'h100, 6'b100010, 1);
        add("t3_data",    0, 0, 1, 1, 0, 0, 32'h200, 32'h100, 6'b010010, 2);
        add("t3_r2",      0, 0, 0, 0, 1, 32'hF0, 0, 0, 6'b001000, 0);
        add("t3_r3",      0, 0, 0, 0, 1, 32'hF4, 0, 0, 6'b000100, 0);
        // fill the ID FIFO; a same-cycle pop does not let a push through
        for (int i = 0; i < 4; i++)
            add("t4_push",  0, 0, 1, 1, 0, 0, 0, 32'h300, 6'b010010, 2);
        add("t4_full",    0, 0, 1, 1, 0, 0, 0, 32'h300, 6'b000000, 0);
        add("t4_popfull", 0, 0, 1, 1, 1, 32'h55, 0, 32'h300, 6'b000100, 0);
        add("t4_push5",   0, 0, 1, 1, 0, 0, 0, 32'h300, 6'b010010, 2);
        for (int i = 0; i < 4; i++)
            add("t4_drain", 0, 0, 0, 0, 1, 32'h60, 0, 0, 6'b000100, 0);
        // interleaved response routing
        add("t5_i0",      0, 1, 0, 1, 0, 0, 32'h400, 0, 6'b100010, 1);
        add("t5_d",       0, 0, 1, 1, 0, 0, 0, 32'h500, 6'b010010, 2);
        add("t5_i1",      0, 1, 0, 1, 0, 0, 32'h404, 0, 6'b100010, 1);
        add("t5_rA",      0, 0, 0, 0, 1, 32'hA, 0, 0, 6'b001000, 0);
        add("t5_rB",      0, 0, 0, 0, 1, 32'hB, 0, 0, 6'b000100, 0);
        add("t5_rC",      0, 0, 0, 0, 1, 32'hC, 0, 0, 6'b001000, 0);
        // stray response, sticky error, reset with two outstanding
        add("t6_stray",   0, 0, 0, 0, 1, 32'h77, 0, 0, 6'b000000, 0);
        add("t6_err",     0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 0);
        add("t6_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 0);
        add("t6_i",       0, 1, 0, 1, 0, 0, 32'h600, 0, 6'b100011, 1);
        add("t6_d",       0, 0, 1, 1, 0, 0, 0, 32'h700, 6'b010011, 2);
        add("t6_rst",     1, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 0);
        add("t6_clr",     0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
        add("t6_late",    0, 0, 0, 0, 1, 32'h88, 0, 0, 6'b000000, 0);
        add("t6_late_err",0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 0);

        do_reset();
        foreach (vq[i]) apply(vq[i]);

        // Starvation: inst held throughout, data held for 6 accepts, one response per cycle.
        do_reset();
        exp_ord = "DDDDIDDI";
        dacc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(0, 1, dacc < 6, 1, c > 0, c, 32'h800 + c, 32'h900 + c);
            #1;
            got_c = inst_addr_ok ? "I" : (data_addr_ok ? "D" : "-");
            exp_c = exp_ord[c];
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL starve_grant[%0d]: got %c expected %c", c, got_c, exp_c);
            end
            if (c > 0) begin
                exp_c = exp_ord[c-1];
                checks++;
                if ({inst_data_ok, data_data_ok} !== ((exp_c == "I") ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL starve_resp[%0d]: got %b%b expected source %c",
                             c, inst_data_ok, data_data_ok, exp_c);
                end
            end
            if (data_addr_ok) dacc++;
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h99, 0, 0);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok, resp_err} !== 3'b100) begin
            errors++;
            $display("FAIL starve_last: got %b%b%b expected 100", inst_data_ok, data_data_ok, resp_err);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({mem_req, inst_data_ok, data_data_ok, resp_err} !== 4'b0000) begin
            errors++;
            $display("FAIL starve_idle: got %b%b%b%b expected 0000",
                     mem_req, inst_data_ok, data_data_ok, resp_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU instruction-fetch master and data-access master. Sits between the pipeline (IF and EXE/MEM request and response paths) and the downstream bridge.
- Arbitrates requests with data priority and a starvation guard.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response (data_ok/rdata) back to its originating master.

Parameters:
MAX_OUTSTANDING, 4, depth of the source-ID FIFO (power of 2, >=2); maximum accepted-but-unanswered transactions.
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced ahead.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  instruction master request valid
inst_wr  in  1  write (normally 0)
inst_size  in  2  0=byte, 1=half, 2=word
inst_wstrb  in  4  byte strobes
inst_addr  in  32  address
inst_wdata  in  32  write data
inst_addr_ok  out  1  request accepted this cycle
inst_data_ok  out  1  response for inst this cycle
inst_rdata  out  32  read data
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master request, same meaning
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  response for data
data_rdata  out  32  read data
mem_req  out  1  downstream request
mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed payload of granted master
mem_addr_ok  in  1  downstream accept
mem_data_ok  in  1  downstream response (in order)
mem_rdata  in  32  downstream read data
resp_err  out  1  sticky: mem_data_ok seen with FIFO empty

Behaviour:
- Handshake: a master holds req and payload stable until its addr_ok. A transfer occurs when mem_req & mem_addr_ok. Request path is combinational, so addr_ok can be returned in the same cycle as req.
- Grant state register lock in {NONE, INST, DATA}, reset NONE.
  - NONE: if FIFO not full, grant by priority. lock becomes the granted master if mem_req is asserted and mem_addr_ok=0. It stays NONE if the request is accepted that cycle.
  - INST/DATA: payload is held from the locked master; mem_req = that master's req. Return to NONE on mem_addr_ok.
  - No re-arbitration while locked, even if a higher-priority request arrives.
- Priority in NONE: data wins over inst, unless starve_cnt == STARVE_LIMIT and inst_req=1, in which case inst wins.
- starve_cnt, reset 0:
  - Increments on each accepted data transfer while inst_req=1, saturating at STARVE_LIMIT.
  - Clears on an accepted inst transfer or whenever inst_req=0.
- mem_req = granted master's req & ~fifo_full. When the FIFO is full, mem_req=0 and no grant is made. An existing lock persists, but mem_req stays low until there is space.
- Full means count == MAX_OUTSTANDING, evaluated on the registered count. A same-cycle pop does not free space for a push in that cycle.
- addr_ok to the granted master = mem_addr_ok & mem_req. The non-granted master's addr_ok = 0.
- ID FIFO:
  - Push the 1-bit source (0=inst, 1=data) on each accepted transfer.
  - Pop on mem_data_ok when not empty.
  - Pointers wrap modulo MAX_OUTSTANDING; count is clog2(MAX_OUTSTANDING)+1 bits.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Response routing (combinational): inst_data_ok = mem_data_ok & ~empty & head==0; data_data_ok = mem_data_ok & ~empty & head==1. inst_rdata = data_rdata = mem_rdata.
- mem_data_ok with the FIFO empty: ignored (no data_ok to either master, no pop), and resp_err is set until reset.
- Reset values: lock=NONE, count=0, pointers=0, starve_cnt=0, resp_err=0. All outputs are combinational from these and the inputs, so with req inputs low all outputs are 0.
- Reset asserted mid-transaction drops all outstanding IDs; responses arriving after reset trigger resp_err. The downstream must be reset together with this block.

Test Plan:
1. Single inst read, addr 0x1C000000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata 0x02800C0C -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x02800C0C in cycle 2; data_data_ok=0 throughout.
2. inst_req and data_req both asserted, mem_addr_ok=1 every cycle -> data granted first; order continues per priority. With data_req held for 6 requests, inst is granted after exactly 4 data grants (STARVE_LIMIT=4), then data resumes.
3. Lock: data_req at addr 0x100 with mem_addr_ok=0 for 3 cycles while inst_req is also asserted -> mem_addr stays 0x100, inst_addr_ok=0; lock releases on the cycle mem_addr_ok=1.
4. FIFO full: 4 accepted transfers with no data_ok -> mem_req=0 on the 5th request. mem_data_ok and a new request in the same cycle -> no push that cycle; push occurs the next cycle.
5. Interleaved order inst, data, inst, with responses rdata 0xA, 0xB, 0xC -> inst_data_ok(0xA), data_data_ok(0xB), inst_data_ok(0xC).
6. mem_data_ok with FIFO empty -> no data_ok to either master, resp_err=1 and sticky. Reset with 2 outstanding -> count=0, resp_err=0.
